set_mode_ctrl: RTL and testbench

- Time-setting controller for the clock display: turns raw mode/up/down buttons into the alarm_mode code consumed by the digit-select/blink driver.
- Issues increment/decrement pulses to the time counters for the field under edit and freezes seconds counting while seconds are edited.
- Sits between the board buttons and the time-counter and display blocks, clocked by msecclk (1 kHz).

---
 rtl/clock_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/set_mode_ctrl.sv | 166 ++++++++++++++++
 tb/tb_set_mode_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display: the alarm_mode field codes used by
// the time-setting controller and the digit-select/blink driver.
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_NORMAL = 3'd0,
    MODE_SEC    = 3'd1,
    MODE_MIN    = 3'd2,
    MODE_HOUR   = 3'd3
  } mode_e;

  // Mode button walks NORMAL -> SEC -> MIN -> HOUR -> NORMAL.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_NORMAL: return MODE_SEC;
      MODE_SEC:    return MODE_MIN;
      MODE_MIN:    return MODE_HOUR;
      default:     return MODE_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One board button: 2-flop synchronizer, debounce counter and a press pulse
// on the clean 0->1 edge.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic msecclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw input and count how long the synced value has
  // disagreed with the clean level; any return to agreement restarts the count.
  always_ff @(posedge msecclk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_MS)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Press is combinational so the controller can register its reaction on
  // the very next edge.
  assign press = level & ~level_q;

endmodule

// File: rtl/set_mode_ctrl.sv
// Time-setting controller: turns the mode/up/down buttons into the field
// under edit (alarm_mode), single-cycle adjust pulses with auto-repeat, and
// the seconds-freeze flag.
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000
) (
  input  logic       msecclk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] alarm_mode,
  output logic       adj_inc,
  output logic       adj_dec,
  output logic       hold_time
);

  localparam int RPT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_MS + 1);

  // Only the mode button's press edge matters; its clean level is not used.
  logic mode_level_unused;
  logic mode_press;
  logic up_level;
  logic up_press;
  logic down_level;
  logic down_press;

  mode_e            state;
  logic [RPT_W-1:0] up_cnt;
  logic [RPT_W-1:0] down_cnt;
  logic             up_rate;
  logic             down_rate;
  logic [TO_W-1:0]  tout_cnt;

  logic  setting;
  logic  both_held;
  logic  up_rpt;
  logic  down_rpt;
  logic  up_evt;
  logic  down_evt;
  logic  up_restart;
  logic  down_restart;
  logic  tout_clear;
  logic  timeout_hit;
  mode_e next_state;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_mode (
    .msecclk (msecclk),
    .reset   (reset),
    .raw     (btn_mode),
    .level   (mode_level_unused),
    .press   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_up (
    .msecclk (msecclk),
    .reset   (reset),
    .raw     (btn_up),
    .level   (up_level),
    .press   (up_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_down (
    .msecclk (msecclk),
    .reset   (reset),
    .raw     (btn_down),
    .level   (down_level),
    .press   (down_press)
  );

  // Decide this cycle's adjust events, repeat restarts, timeout and next mode.
  // A mode press overrides any adjust; holding up and down together disables
  // both so a stuck pair cannot spin a field.
  always_comb begin
    setting   = (state != MODE_NORMAL);
    both_held = up_level & down_level;

    up_rpt   = setting & up_level & ~both_held &
               (up_rate ? (up_cnt == RPT_W'(REPEAT_RATE_MS - 1))
                        : (up_cnt == RPT_W'(REPEAT_DELAY_MS - 1)));
    down_rpt = setting & down_level & ~both_held &
               (down_rate ? (down_cnt == RPT_W'(REPEAT_RATE_MS - 1))
                          : (down_cnt == RPT_W'(REPEAT_DELAY_MS - 1)));

    up_evt   = setting & ~both_held & ~mode_press & (up_press | up_rpt);
    down_evt = setting & ~both_held & ~mode_press & (down_press | down_rpt);

    up_restart   = ~setting | ~up_level | both_held | mode_press | up_press;
    down_restart = ~setting | ~down_level | both_held | mode_press | down_press;

    tout_clear  = ~setting | mode_press | up_press | down_press | up_rpt | down_rpt;
    timeout_hit = setting & ~tout_clear & (tout_cnt == TO_W'(TIMEOUT_MS - 1));

    next_state = state;
    if (mode_press) begin
      next_state = next_mode(state);
    end else if (timeout_hit) begin
      next_state = MODE_NORMAL;
    end
  end

  // Hold counters: restart in the delay phase on a press or any blocking
  // condition, switch to the rate phase after each repeat pulse.
  always_ff @(posedge msecclk) begin
    if (reset) begin
      up_cnt    <= '0;
      up_rate   <= 1'b0;
      down_cnt  <= '0;
      down_rate <= 1'b0;
    end else begin
      if (up_restart) begin
        up_cnt  <= '0;
        up_rate <= 1'b0;
      end else if (up_rpt) begin
        up_cnt  <= '0;
        up_rate <= 1'b1;
      end else begin
        up_cnt <= up_cnt + RPT_W'(1);
      end

      if (down_restart) begin
        down_cnt  <= '0;
        down_rate <= 1'b0;
      end else if (down_rpt) begin
        down_cnt  <= '0;
        down_rate <= 1'b1;
      end else begin
        down_cnt <= down_cnt + RPT_W'(1);
      end
    end
  end

  // Inactivity counter for the setting states, saturating at the timeout.
  always_ff @(posedge msecclk) begin
    if (reset || tout_clear) begin
      tout_cnt <= '0;
    end else if (tout_cnt != TO_W'(TIMEOUT_MS)) begin
      tout_cnt <= tout_cnt + TO_W'(1);
    end
  end

  // Mode FSM with registered adjust pulses and seconds-freeze flag.
  always_ff @(posedge msecclk) begin
    if (reset) begin
      state     <= MODE_NORMAL;
      adj_inc   <= 1'b0;
      adj_dec   <= 1'b0;
      hold_time <= 1'b0;
    end else begin
      state     <= next_state;
      adj_inc   <= up_evt;
      adj_dec   <= down_evt;
      hold_time <= (next_state == MODE_SEC);
    end
  end

  assign alarm_mode = state;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: table of button presses with expected mode,
// a pulse scoreboard fed at stimulus time, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_set_mode_ctrl;

  localparam int DEB   = 20;
  localparam int DELAY = 500;
  localparam int RATE  = 100;
  localparam int TOUT  = 10000;
  localparam int LAT   = DEB + 4;

  logic       msecclk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] alarm_mode;
  logic       adj_inc;
  logic       adj_dec;
  logic       hold_time;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    bit inc;
  } pulse_t;

  typedef struct {
    int         btn;
    int         hold;
    int         n_pulses;
    logic [2:0] exp_mode;
    logic       exp_hold;
  } vec_t;

  pulse_t exp_q[$];
  pulse_t got;
  vec_t   vecs[12];

  set_mode_ctrl dut (
    .msecclk    (msecclk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .alarm_mode (alarm_mode),
    .adj_inc    (adj_inc),
    .adj_dec    (adj_dec),
    .hold_time  (hold_time)
  );

  always #5 msecclk = ~msecclk;

  always @(posedge msecclk) cyc <= cyc + 1;

  // Scoreboard: every adjust pulse must match the next expected entry.
  always @(negedge msecclk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missed_pulse: actual=none required=%s at cycle %0d",
               exp_q[0].inc ? "inc" : "dec", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (adj_inc || adj_dec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_pulse: actual inc=%b dec=%b at cycle %0d required=none",
                 adj_inc, adj_dec, cyc);
      end else begin
        got = exp_q.pop_front();
        if (got.cyc != cyc || adj_inc != got.inc || adj_dec != !got.inc) begin
          n_fail++;
          $display("[TB] FAIL pulse: actual inc=%b dec=%b cycle=%0d required inc=%b cycle=%0d",
                   adj_inc, adj_dec, cyc, got.inc, got.cyc);
        end
      end
      n_checks++;
      if ((adj_inc && adj_dec) || alarm_mode == 3'd0) begin
        n_fail++;
        $display("[TB] FAIL pulse_invariant: actual inc=%b dec=%b mode=%0d required one pulse in mode 1-3",
                 adj_inc, adj_dec, alarm_mode);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setBtn(input int btn, input logic v);
    case (btn)
      0:       btn_mode = v;
      1:       btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) begin
      @(posedge msecclk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp_mode, input logic exp_hold);
    n_checks++;
    if ({alarm_mode, adj_inc, adj_dec, hold_time} !== {exp_mode, 1'b0, 1'b0, exp_hold}) begin
      n_fail++;
      $display("[TB] FAIL %s: actual mode/inc/dec/hold=%0d/%b/%b/%b required=%0d/0/0/%b",
               name, alarm_mode, adj_inc, adj_dec, hold_time, exp_mode, exp_hold);
    end
  endtask

  task automatic applyStimulus(input int btn, input int hold, input int n_pulses, output int start);
    @(posedge msecclk);
    #1;
    start = cyc;
    for (int k = 0; k < n_pulses; k++) begin
      exp_q.push_back('{start + LAT + ((k == 0) ? 0 : DELAY + RATE * (k - 1)), btn == 1});
    end
    setBtn(btn, 1'b1);
    repeat (hold) @(posedge msecclk);
    #1;
    setBtn(btn, 1'b0);
    repeat (40) @(posedge msecclk);
    #1;
  endtask

  initial begin
    int c;
    int d;
    int p;
    int r;

    vecs[0]  = '{0, 5,   0, 3'd0, 1'b0};
    vecs[1]  = '{1, 30,  0, 3'd0, 1'b0};
    vecs[2]  = '{0, 30,  0, 3'd1, 1'b1};
    vecs[3]  = '{2, 30,  1, 3'd1, 1'b1};
    vecs[4]  = '{0, 30,  0, 3'd2, 1'b0};
    vecs[5]  = '{1, 800, 4, 3'd2, 1'b0};
    vecs[6]  = '{0, 30,  0, 3'd3, 1'b0};
    vecs[7]  = '{2, 40,  1, 3'd3, 1'b0};
    vecs[8]  = '{0, 30,  0, 3'd0, 1'b0};
    vecs[9]  = '{2, 30,  0, 3'd0, 1'b0};
    vecs[10] = '{0, 30,  0, 3'd1, 1'b1};
    vecs[11] = '{1, 10,  0, 3'd1, 1'b1};

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(posedge msecclk);
    @(negedge msecclk);
    checkOutput("reset_state", 3'd0, 1'b0);
    @(posedge msecclk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      repeat (10) @(posedge msecclk);
      @(negedge msecclk);
      checkOutput("idle", 3'd0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].hold, vecs[i].n_pulses, c);
      @(negedge msecclk);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_mode, vecs[i].exp_hold);
    end

    // Exact press latency, SEC -> MIN.
    @(posedge msecclk);
    #1;
    c = cyc;
    btn_mode = 1'b1;
    waitUntil(c + LAT - 1);
    @(negedge msecclk);
    checkOutput("latency_before", 3'd1, 1'b1);
    waitUntil(c + LAT);
    @(negedge msecclk);
    checkOutput("latency_after", 3'd2, 1'b0);
    waitUntil(c + 30);
    btn_mode = 1'b0;
    waitUntil(c + 70);

    // Inactivity in HOUR falls back to NORMAL exactly at the timeout.
    c = cyc;
    p = c + LAT;
    btn_mode = 1'b1;
    waitUntil(c + 30);
    btn_mode = 1'b0;
    waitUntil(p + TOUT - 1);
    @(negedge msecclk);
    checkOutput("timeout_before", 3'd3, 1'b0);
    waitUntil(p + TOUT);
    @(negedge msecclk);
    checkOutput("timeout_after", 3'd0, 1'b0);

    // An up press one cycle before the timeout keeps HOUR.
    applyStimulus(0, 30, 0, c);
    applyStimulus(0, 30, 0, c);
    applyStimulus(0, 30, 0, c);
    @(negedge msecclk);
    checkOutput("to_hour", 3'd3, 1'b0);
    p = c + LAT;
    waitUntil(p + TOUT - 1 - LAT);
    exp_q.push_back('{cyc + LAT, 1'b1});
    btn_up = 1'b1;
    waitUntil(p + TOUT - 1 - LAT + 30);
    btn_up = 1'b0;
    waitUntil(p + TOUT + 5);
    @(negedge msecclk);
    checkOutput("timeout_rescued", 3'd3, 1'b0);

    // Up and down held together in SEC, then down released.
    applyStimulus(0, 30, 0, c);
    applyStimulus(0, 30, 0, c);
    @(negedge msecclk);
    checkOutput("to_sec", 3'd1, 1'b1);
    @(posedge msecclk);
    #1;
    c = cyc;
    exp_q.push_back('{c + LAT, 1'b1});
    btn_up = 1'b1;
    waitUntil(c + 5);
    btn_down = 1'b1;
    waitUntil(c + 1005);
    d = cyc;
    btn_down = 1'b0;
    exp_q.push_back('{d + DEB + 3 + DELAY, 1'b1});
    exp_q.push_back('{d + DEB + 3 + DELAY + RATE, 1'b1});
    waitUntil(d + 650);
    btn_up = 1'b0;
    waitUntil(d + 700);
    @(negedge msecclk);
    checkOutput("both_release", 3'd1, 1'b1);

    // Mode and up pressed in the same cycle while in MIN.
    applyStimulus(0, 30, 0, c);
    @(negedge msecclk);
    checkOutput("to_min", 3'd2, 1'b0);
    @(posedge msecclk);
    #1;
    c = cyc;
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    waitUntil(c + 30);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    waitUntil(c + 70);
    @(negedge msecclk);
    checkOutput("mode_up_same", 3'd3, 1'b0);

    // Reset mid-repeat, with mode and up held through reset release.
    @(posedge msecclk);
    #1;
    c = cyc;
    exp_q.push_back('{c + LAT, 1'b1});
    exp_q.push_back('{c + LAT + DELAY, 1'b1});
    btn_up = 1'b1;
    waitUntil(c + 550);
    reset = 1'b1;
    waitUntil(c + 551);
    @(negedge msecclk);
    checkOutput("reset_mid_repeat", 3'd0, 1'b0);
    waitUntil(c + 552);
    btn_mode = 1'b1;
    waitUntil(c + 553);
    reset = 1'b0;
    r = c + 554;
    waitUntil(r + DEB + 2);
    @(negedge msecclk);
    checkOutput("held_reset_before", 3'd0, 1'b0);
    waitUntil(r + DEB + 3);
    @(negedge msecclk);
    checkOutput("held_reset_after", 3'd1, 1'b1);
    @(posedge msecclk);
    #1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (40) @(posedge msecclk);
    @(negedge msecclk);
    checkOutput("final", 3'd1, 1'b1);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_pulses: actual=%0d outstanding required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
